// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg: shared types and constants for the 4x4 sliding-tile board engine.
//   - cell encoding: 4-bit exponent (0 empty, n -> tile 2^n)
//   - board layout: cell i = board[i], row i/4, col i%4, cell 0 top-left
//   - move directions, FSM states, LFSR seed/taps, reset board
//   - cell_idx(): maps (direction, lane, position-from-destination) to a cell
//   - lfsr_next(): one step of the 16-bit Galois LFSR
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int CELL_W    = 4;
    localparam int LANE_LEN  = 4;
    localparam int NUM_CELLS = 16;

    localparam logic [CELL_W-1:0] CELL_MAX = 4'd15;  // 15,15 must not merge
    localparam logic [CELL_W-1:0] WIN_EXP  = 4'd11;  // 2^11 = 2048

    typedef logic [CELL_W-1:0]      cell_t;
    typedef cell_t [LANE_LEN-1:0]   lane_t;   // element 0 = destination edge
    typedef cell_t [NUM_CELLS-1:0]  board_t;  // 64 bits, cell i at [4i+3:4i]

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LANE,
        ST_SPAWN,
        ST_DONE
    } state_e;

    // Galois LFSR for x^16 + x^14 + x^13 + x^11 (right-shifting form).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam board_t RESET_BOARD = 64'h1000_0000_0000_0001;

    // Cell index {row, col} for position pos of a lane, counted from the
    // edge the tiles slide toward.
    function automatic logic [3:0] cell_idx(input dir_e dir, input logic [1:0] lane,
                                            input logic [1:0] pos);
        case (dir)
            DIR_LEFT:  return {lane, pos};
            DIR_RIGHT: return {lane, ~pos};
            DIR_UP:    return {pos, lane};
            default:   return {~pos, lane};  // DIR_DOWN
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/lane_slide.sv
// ---------------------------------------------------------------------------
// lane_slide: combinational slide/merge of one 4-cell lane.
//   lane_i : lane_t in, element 0 nearest the destination edge
//   lane_o : lane_t out, compacted toward element 0 with equal adjacent
//            pairs merged front-first, each tile merged at most once
// ---------------------------------------------------------------------------
module lane_slide
    import game_pkg::*;
(
    input  lane_t lane_i,
    output lane_t lane_o
);

    cell_t      packed_c [8];  // spare tail entries read as empty
    logic [2:0] n_cnt;
    logic [2:0] k_cnt;
    logic       skip;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned, which would infer a latch.
        for (int i = 0; i < 8; i++) packed_c[i] = '0;
        n_cnt  = '0;
        k_cnt  = '0;
        skip   = 1'b0;
        lane_o = '0;

        // Compact non-empty cells toward the front.
        for (int j = 0; j < LANE_LEN; j++) begin
            if (lane_i[j] != '0) begin
                packed_c[n_cnt] = lane_i[j];
                n_cnt           = n_cnt + 3'd1;
            end
        end

        // Merge front-first; writing into a fresh lane recompacts for free.
        for (int j = 0; j < LANE_LEN; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (packed_c[j] != '0 && packed_c[j] == packed_c[j+1]
                         && packed_c[j] != CELL_MAX) begin
                lane_o[k_cnt[1:0]] = packed_c[j] + 4'd1;
                k_cnt              = k_cnt + 3'd1;
                skip               = 1'b1;
            end else if (packed_c[j] != '0) begin
                lane_o[k_cnt[1:0]] = packed_c[j];
                k_cnt              = k_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/board_engine.sv
// ---------------------------------------------------------------------------
// board_engine: 4x4 sliding-tile game board with move/load handshake.
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   move_valid, move_dir    : move request (00 left, 01 right, 10 up, 11 down)
//   move_ready              : high in IDLE; a move or load is accepted then
//   load_en, load_values    : load a whole board (move wins on the same edge)
//   values                  : committed board, cell i = values[4i+3:4i]
//   done                    : one-cycle pulse when a move commits
//   changed                 : last committed move altered the board
//   game_over, win          : registered status of the committed board
// A move runs IDLE -> LANE x4 -> SPAWN -> DONE on a private working copy so
// values keeps showing the old board until commit.
// ---------------------------------------------------------------------------
module board_engine
    import game_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic        load_en,
    input  logic [63:0] load_values,
    output logic [63:0] values,
    output logic        done,
    output logic        changed,
    output logic        game_over,
    output logic        win
);

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    dir_e        dir_q, dir_d;
    board_t      work_q, work_d;
    board_t      values_q, values_d;
    logic        changed_q, changed_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        game_over_q, game_over_d;
    logic        win_q, win_d;

    lane_t       lane_in, lane_out;
    board_t      spawn_board;
    cell_t       spawn_tile;
    logic [3:0]  spawn_idx;
    logic        spawn_found;

    // Gather the current lane from the working copy, destination edge first.
    always_comb begin
        lane_in = '0;
        for (int p = 0; p < LANE_LEN; p++)
            lane_in[p] = work_q[cell_idx(dir_q, lane_q, 2'(p))];
    end

    lane_slide u_lane_slide (
        .lane_i (lane_in),
        .lane_o (lane_out)
    );

    // Spawn candidate: first empty cell scanning upward from lfsr[3:0].
    always_comb begin
        spawn_board = work_q;
        spawn_found = 1'b0;
        spawn_idx   = '0;
        spawn_tile  = (lfsr_q[7:5] == 3'd0) ? 4'd2 : 4'd1;
        for (int off = 0; off < NUM_CELLS; off++) begin
            spawn_idx = lfsr_q[3:0] + 4'(off);
            if (!spawn_found && work_q[spawn_idx] == '0) begin
                spawn_board[spawn_idx] = spawn_tile;
                spawn_found            = 1'b1;
            end
        end
    end

    // Board status from the committed board.
    always_comb begin
        game_over_d = 1'b1;
        win_d       = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (values_q[{2'(r), 2'(c)}] == '0)
                    game_over_d = 1'b0;
                if (values_q[{2'(r), 2'(c)}] >= WIN_EXP)
                    win_d = 1'b1;
                if (c < 3 && values_q[{2'(r), 2'(c)}] == values_q[{2'(r), 2'(c + 1)}])
                    game_over_d = 1'b0;
                if (r < 3 && values_q[{2'(r), 2'(c)}] == values_q[{2'(r + 1), 2'(c)}])
                    game_over_d = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        dir_d     = dir_q;
        work_d    = work_q;
        values_d  = values_q;
        changed_d = changed_q;
        lfsr_d    = lfsr_q;

        case (state_q)
            ST_IDLE: begin
                if (move_valid) begin
                    work_d  = values_q;
                    dir_d   = dir_e'(move_dir);
                    lane_d  = 2'd0;
                    state_d = ST_LANE;
                end else if (load_en) begin
                    values_d = load_values;
                end
            end
            ST_LANE: begin
                for (int p = 0; p < LANE_LEN; p++)
                    work_d[cell_idx(dir_q, lane_q, 2'(p))] = lane_out[p];
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd3)
                    state_d = ST_SPAWN;
            end
            ST_SPAWN: begin
                // An unchanged board neither spawns nor consumes LFSR state.
                if (work_q != values_q) begin
                    values_d  = spawn_board;
                    lfsr_d    = lfsr_next(lfsr_q);
                    changed_d = 1'b1;
                end else begin
                    changed_d = 1'b0;
                end
                state_d = ST_DONE;
            end
            default: begin  // ST_DONE
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its _d value from before this edge.
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= 2'd0;
            dir_q       <= DIR_LEFT;
            values_q    <= RESET_BOARD;
            changed_q   <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            dir_q       <= dir_d;
            values_q    <= values_d;
            changed_q   <= changed_d;
            lfsr_q      <= lfsr_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
        end
    end

    // NOTE: the working copy is left out of reset; it is always loaded from
    // values on move accept before anything reads it.
    always_ff @(posedge clock) begin
        work_q <= work_d;
    end

    assign move_ready = (state_q == ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign values     = values_q;
    assign changed    = changed_q;
    assign game_over  = game_over_q;
    assign win        = win_q;

endmodule

// File: tb/tb_board_engine.sv
// ---------------------------------------------------------------------------
// tb_board_engine: directed self-checking bench for board_engine.
// Expected boards are hand-derived; LFSR sequence from seed 16'hACE1 is
// ACE1 -> E270 -> 7138 -> 389C -> 1C4E (spawn start = low nibble).
// ---------------------------------------------------------------------------
module tb_board_engine;

    localparam logic [1:0] LEFT  = 2'b00;
    localparam logic [1:0] RIGHT = 2'b01;
    localparam logic [1:0] UP    = 2'b10;
    localparam logic [1:0] DOWN  = 2'b11;

    localparam logic [63:0] RESET_V   = 64'h1000_0000_0000_0001;
    localparam logic [63:0] CHECKER_V = 64'h1212_2121_1212_2121;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  move_dir = 2'b00;
    logic        move_ready;
    logic        load_en = 1'b0;
    logic [63:0] load_values = '0;
    logic [63:0] values;
    logic        done;
    logic        changed;
    logic        game_over;
    logic        win;

    int vectors     = 0;
    int miscompares = 0;
    int done_count;

    board_engine dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_ready  (move_ready),
        .load_en     (load_en),
        .load_values (load_values),
        .values      (values),
        .done        (done),
        .changed     (changed),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clock = ~clock;

    // Advance to 1 ns after the next rising edge; sample and drive there.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic load_board(input logic [63:0] v, input string tag);
        load_en     = 1'b1;
        load_values = v;
        tick();
        load_en     = 1'b0;
        check(tag, values, v);
    endtask

    // Issue one move at edge k and check the k+4 / k+5 / k+6 timeline.
    task automatic do_move(input logic [1:0] dir, input logic [63:0] old_v,
                           input logic [63:0] new_v, input logic exp_changed,
                           input string tag);
        move_valid = 1'b1;
        move_dir   = dir;
        tick();                                   // edge k
        move_valid = 1'b0;
        check({tag, " ready_low"}, 64'(move_ready), 64'd0);
        repeat (4) tick();                        // edge k+4
        check({tag, " old_values_k4"}, values, old_v);
        check({tag, " no_done_k4"}, 64'(done), 64'd0);
        tick();                                   // edge k+5
        check({tag, " done_k5"}, 64'(done), 64'd1);
        check({tag, " values_k5"}, values, new_v);
        check({tag, " changed"}, 64'(changed), 64'(exp_changed));
        tick();                                   // edge k+6
        check({tag, " done_clear_k6"}, 64'(done), 64'd0);
        check({tag, " ready_k6"}, 64'(move_ready), 64'd1);
    endtask

    initial begin
        // Reset state.
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        check("reset values", values, RESET_V);
        check("reset ready", 64'(move_ready), 64'd1);
        check("reset done", 64'(done), 64'd0);
        check("reset changed", 64'(changed), 64'd0);
        check("reset game_over", 64'(game_over), 64'd0);
        check("reset win", 64'(win), 64'd0);

        // row0=[1,1,2,2] left -> [2,3,spawn 1 at cell2,0] (lfsr ACE1).
        load_board(64'h0000_0000_0000_2211, "load pairs");
        do_move(LEFT, 64'h0000_0000_0000_2211, 64'h0000_0000_0000_0132, 1'b1, "left pairs");

        // row0=[2,2,2,0] left -> [3,2,spawn 1 at cell2] (lfsr E270).
        load_board(64'h0000_0000_0000_0222, "load triple");
        do_move(LEFT, 64'h0000_0000_0000_0222, 64'h0000_0000_0000_0123, 1'b1, "left triple");

        // 15,15 never merges: no motion, no spawn, changed=0.
        load_board(64'h0000_0000_0000_00FF, "load max pair");
        do_move(LEFT, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF, 1'b0, "left max pair");

        // Checkerboard: game over; move still runs with changed=0.
        load_board(CHECKER_V, "load checker");
        tick();
        check("checker game_over", 64'(game_over), 64'd1);
        check("checker win", 64'(win), 64'd0);
        do_move(UP, CHECKER_V, CHECKER_V, 1'b0, "up checker");

        // LFSR must still be 7138 here: spawn lands on cell 8.
        load_board(64'h0000_0000_0000_0010, "load single");
        do_move(LEFT, 64'h0000_0000_0000_0010, 64'h0000_0001_0000_0001, 1'b1, "lfsr hold");
        check("single game_over", 64'(game_over), 64'd0);

        // move_valid held and load_en strobed while busy: one move only.
        load_board(64'h0000_0000_0000_1000, "load hold");
        move_valid  = 1'b1;
        move_dir    = LEFT;
        tick();                                   // edge k
        load_en     = 1'b1;
        load_values = 64'hFFFF_FFFF_FFFF_FFFF;
        done_count  = 0;
        for (int i = 0; i < 6; i++) begin         // edges k+1 .. k+6
            tick();
            if (done) done_count++;
        end
        check("hold ready_k6", 64'(move_ready), 64'd1);
        move_valid = 1'b0;
        load_en    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) done_count++;
        end
        check("hold single done", 64'(done_count), 64'd1);
        check("hold values", values, 64'h0001_0000_0000_0001);

        // Reset at k+3 aborts the move: reset board, no done.
        load_board(64'h0000_0000_0000_1000, "load abort");
        move_valid = 1'b1;
        move_dir   = LEFT;
        tick();                                   // edge k
        move_valid = 1'b0;
        repeat (2) tick();                        // edge k+2
        reset_n = 1'b0;
        tick();                                   // edge k+3
        reset_n = 1'b1;
        check("abort values", values, RESET_V);
        check("abort ready", 64'(move_ready), 64'd1);
        check("abort changed", 64'(changed), 64'd0);
        done_count = (done) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) done_count++;
        end
        check("abort no done", 64'(done_count), 64'd0);
        check("abort values held", values, RESET_V);

        // LFSR back at ACE1 after reset: spawn at cell 1.
        do_move(RIGHT, RESET_V, 64'h1000_0000_0000_1010, 1'b1, "right after reset");
        // Column lanes: col3 [1,_,_,1] merges into cell15=2; spawn cell0 (E270).
        do_move(DOWN, 64'h1000_0000_0000_1010, 64'h2010_0000_0000_0001, 1'b1, "down merge");

        // Win flag one cycle after loading a 2048 tile.
        load_board(64'h0000_0000_00B0_0000, "load win");
        tick();
        check("win flag", 64'(win), 64'd1);
        check("win game_over", 64'(game_over), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/board_engine.md
BOARD_ENGINE -- requirements
Module: board_engine

Interface
REQ-001 SHALL have ports: clock, input, 1, system clock (all logic on rising edge).
REQ-002 SHALL have ports: reset_n, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have ports: move_valid, input, 1, move request; move_dir, input, 2, 00 left, 01 right, 10 up, 11 down.
REQ-004 SHALL have ports: move_ready, output, 1, high when IDLE and able to accept a move or load.
REQ-005 SHALL have ports: load_en, input, 1, load strobe; load_values, input, 64, board to load.
REQ-006 SHALL have ports: values, output, 64, committed board; cell i = values[4i+3:4i], row i/4, col i%4, cell 0 top-left.
REQ-007 SHALL have ports: done, output, 1, one-cycle pulse when a move commits (redraw trigger for draw stage).
REQ-008 SHALL have ports: changed, output, 1, last move altered board; game_over, output, 1; win, output, 1.

Function
REQ-009 SHALL encode cells as exponent: 0 empty, n = tile 2^n, n in 1..15.
REQ-010 SHALL accept a move on an edge where move_valid && move_ready; load_en is ignored on that edge.
REQ-011 SHALL, when load_en && move_ready, copy load_values to values on that edge; changed unchanged, no done.
REQ-012 SHALL ignore move_valid and load_en while move_ready is low (no queuing).
REQ-013 SHALL use states IDLE -> LANE (4 cycles, lane 0..3) -> SPAWN (1 cycle) -> DONE (1 cycle) -> IDLE.
REQ-014 SHALL process one lane per cycle: lane = row (left/right) or column (up/down), cells ordered from destination edge.
REQ-015 SHALL slide each lane: compact non-zero cells toward the front, merge equal adjacent pairs front-first, each cell merged at most once, recompact.
REQ-016 SHALL merge equal pair e,e into e+1 for e in 1..14; pair 15,15 SHALL NOT merge.
REQ-017 SHALL operate on a working copy; values SHALL hold the old board until commit.
REQ-018 SHALL, in SPAWN, if the working board differs from values, place one tile: start = lfsr[3:0], first empty cell scanning start, start+1, ... mod 16; tile = 2 if lfsr[7:5]==0 else 1; then advance the LFSR once.
REQ-019 SHALL NOT spawn or advance the LFSR when the board is unchanged.
REQ-020 SHALL use a 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11, seed 16'hACE1; the LFSR advances only per REQ-018.
REQ-021 SHALL commit values and changed at the SPAWN->DONE edge; done high exactly in DONE.
REQ-022 SHALL, for a move accepted at edge k, update values at edge k+5, assert done during cycle k+5..k+6, and reassert move_ready at edge k+6.
REQ-023 SHALL register game_over = no empty cell and no horizontally/vertically adjacent equal cells in values; win = any cell >= 11.
REQ-024 SHALL still run and pulse done (changed=0) for a move accepted while game_over is high.

Reset
REQ-025 SHALL on reset_n low at an edge: values = cell0=1, cell15=1, others 0; state IDLE; move_ready 1; done 0; changed 0; game_over 0; win 0; LFSR = 16'hACE1.
REQ-026 SHALL abort any in-flight move on reset with no done pulse; the working copy is discarded.

Structure
REQ-027 SHALL place direction encodings, state enum, cell width, LFSR seed/taps and reset board in shared package game_pkg.
REQ-028 SHALL implement the per-lane slide/merge as combinational sub-module lane_slide (4x4-bit in, 4x4-bit out).

Verification
REQ-029 SHALL check: reset -> values = 64'hF-nibble 1 / nibble0 1 (16'h0001 low, 4'h1 top), move_ready=1, done=0, game_over=0.
REQ-030 SHALL check: load row0=[1,1,2,2], rest 0, move left after reset -> at k+5 values[15:0]=16'h0132 (cells 2,3,1,0), rest 0, changed=1, done 1 cycle.
REQ-031 SHALL check: row0=[2,2,2,0] left -> row0=[3,2,spawn,..]; row=[15,15,0,0] left -> stays [15,15], changed=0 if no other motion.
REQ-032 SHALL check: full checkerboard of 1/2 -> game_over=1; move up -> done pulses, changed=0, values and LFSR unchanged.
REQ-033 SHALL check: move_valid held high during LANE -> only one move processed; reset_n low at k+3 -> reset board, no done.
REQ-034 SHALL check: load with cell5=11 -> win=1 one cycle after load.
